// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: op codes, register-file
// index constants and the datapath FSM state encoding.
package calc_pkg;

    // Op select codes driven by the control FSM on MS_in.
    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_MUL = 3'b011,
        OP_XOR = 3'b100
    } op_e;

    // Register-file index constants; R_NONE disables writes and reads as zero.
    localparam logic [2:0] R_IN1  = 3'd0;
    localparam logic [2:0] R_IN2  = 3'd1;
    localparam logic [2:0] R_RES  = 3'd2;
    localparam logic [2:0] R_NONE = 3'd7;

    // Index 7 is never storage, so only seven physical entries exist.
    localparam int unsigned NUM_REGS = 7;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StMul,
        StWb
    } dp_state_e;

    // Codes 101..111 are reserved and never start an operation.
    function automatic logic is_start_op(input logic [2:0] ms);
        return (ms >= 3'b001) && (ms <= 3'b100);
    endfunction

endpackage

// File: rtl/calc_if.sv
// Control interface between the calculator control FSM (master) and the
// datapath (slave). Optional macro: CALC_OVF_FLAG_EN adds the ovf status line.
interface calc_if #(
    parameter int unsigned WIDTH = 8
);
    logic             WE;
    logic [2:0]       W1;
    logic [2:0]       num_R1;
    logic [2:0]       num_R2;
    logic [2:0]       MS_in;
    logic [WIDTH-1:0] Din;
    logic [WIDTH-1:0] Dout1;
    logic [WIDTH-1:0] Dout2;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             res_valid;
`ifdef CALC_OVF_FLAG_EN
    logic             ovf;

    modport master (
        output WE, W1, num_R1, num_R2, MS_in, Din,
        input  Dout1, Dout2, result, busy, res_valid, ovf
    );

    modport slave (
        input  WE, W1, num_R1, num_R2, MS_in, Din,
        output Dout1, Dout2, result, busy, res_valid, ovf
    );
`else
    modport master (
        output WE, W1, num_R1, num_R2, MS_in, Din,
        input  Dout1, Dout2, result, busy, res_valid
    );

    modport slave (
        input  WE, W1, num_R1, num_R2, MS_in, Din,
        output Dout1, Dout2, result, busy, res_valid
    );
`endif
endinterface

// File: rtl/calc_seq_mul.sv
// Sequential shift-add multiplier: WIDTH accumulate steps after the start
// edge. PROD_W is 2*WIDTH when the full product is needed, else WIDTH.
module calc_seq_mul #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned PROD_W = 2 * WIDTH
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    output logic              done_o,     // final step in progress this cycle
    output logic [PROD_W-1:0] product_o   // complete from the edge after done_o
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [PROD_W-1:0] a_q, a_d;
    logic [PROD_W-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_q, run_d;
    logic              last;

    // Next-state: load operands on start, then one partial product per cycle.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        run_d = run_q;
        last  = run_q && (cnt_q == CNT_W'(WIDTH - 1));
        if (start_i) begin
            a_d   = PROD_W'(a_i);
            b_d   = b_i;
            acc_d = '0;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            if (b_q[cnt_q]) begin
                acc_d = acc_q + (a_q << cnt_q);
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (last) begin
                run_d = 1'b0;
            end
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign done_o    = last;
    assign product_o = acc_q;

endmodule

// File: rtl/calc_datapath.sv
// Calculator datapath: 7-entry register file (index 7 = none/zero) plus ALU
// with single-cycle ADD/SUB/XOR and WIDTH-cycle MUL, result write-back and
// status outputs. Optional macro: CALC_OVF_FLAG_EN adds the ovf flag.
module calc_datapath
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic CLK,
    input  logic RST_N,
    calc_if.slave bus
);
`ifdef CALC_OVF_FLAG_EN
    localparam int unsigned PROD_W = 2 * WIDTH;
`else
    localparam int unsigned PROD_W = WIDTH;
`endif

    dp_state_e        state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       dst_q, dst_d;
    logic [2:0]       ms_prev_q, ms_prev_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] rf_q [NUM_REGS];
    logic [WIDTH-1:0] rf_d [NUM_REGS];

    logic              start;
    logic              mul_start;
    logic              mul_done;
    logic [PROD_W-1:0] mul_product;
    logic              wb_en;
    logic [WIDTH-1:0]  wb_val;
    logic [WIDTH-1:0]  alu_res;

`ifdef CALC_OVF_FLAG_EN
    logic             ovf_q, ovf_d;
    logic             wb_ovf;
    logic             alu_ovf;
    logic [WIDTH:0]   sum_ext;
`else
    logic [WIDTH-1:0] sum_ext;
`endif

    // Combinational register-file reads; index 7 always reads zero.
    assign bus.Dout1 = (bus.num_R1 == R_NONE) ? '0 : rf_q[bus.num_R1];
    assign bus.Dout2 = (bus.num_R2 == R_NONE) ? '0 : rf_q[bus.num_R2];

    // Rising edge of a valid op code; a held code starts only once.
    assign start = is_start_op(bus.MS_in) && (ms_prev_q == OP_NOP);

    calc_seq_mul #(
        .WIDTH  (WIDTH),
        .PROD_W (PROD_W)
    ) u_mul (
        .clk_i     (CLK),
        .rst_ni    (RST_N),
        .start_i   (mul_start),
        .a_i       (bus.Dout1),
        .b_i       (bus.Dout2),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // Single-cycle ALU on the captured operands.
    always_comb begin
        alu_res = '0;
`ifdef CALC_OVF_FLAG_EN
        alu_ovf = 1'b0;
        sum_ext = {1'b0, a_q} + {1'b0, b_q};
`else
        sum_ext = a_q + b_q;
`endif
        case (op_q)
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
`ifdef CALC_OVF_FLAG_EN
                alu_ovf = sum_ext[WIDTH];
`endif
            end
            OP_SUB: begin
                alu_res = a_q - b_q;
`ifdef CALC_OVF_FLAG_EN
                alu_ovf = (a_q < b_q);
`endif
            end
            OP_XOR: alu_res = a_q ^ b_q;
            default: alu_res = '0;
        endcase
    end

    // FSM next-state, operand capture and result write-back.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        dst_d       = dst_q;
        busy_d      = busy_q;
        result_d    = result_q;
        res_valid_d = 1'b0;
        ms_prev_d   = bus.MS_in;
        mul_start   = 1'b0;
        wb_en       = 1'b0;
        wb_val      = alu_res;
`ifdef CALC_OVF_FLAG_EN
        ovf_d       = ovf_q;
        wb_ovf      = alu_ovf;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d    = bus.Dout1;
                    b_d    = bus.Dout2;
                    dst_d  = bus.W1;
                    op_d   = op_e'(bus.MS_in);
                    busy_d = 1'b1;
                    if (bus.MS_in == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = StMul;
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StExec: begin
                wb_en = 1'b1;
            end
            StMul: begin
                if (mul_done) begin
                    state_d = StWb;
                end
            end
            StWb: begin
                wb_en  = 1'b1;
                wb_val = mul_product[WIDTH-1:0];
`ifdef CALC_OVF_FLAG_EN
                wb_ovf = |mul_product[PROD_W-1:WIDTH];
`endif
            end
        endcase
        if (wb_en) begin
            result_d    = wb_val;
            res_valid_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = StIdle;
`ifdef CALC_OVF_FLAG_EN
            ovf_d       = wb_ovf;
`endif
        end
    end

    // Register-file next state; write-back is applied last so it wins a conflict.
    always_comb begin
        rf_d = rf_q;
        if (bus.WE && (bus.W1 != R_NONE)) begin
            rf_d[bus.W1] = bus.Din;
        end
        if (wb_en && (dst_q != R_NONE)) begin
            rf_d[dst_q] = wb_val;
        end
    end

    // State registers; reset aborts any op in flight without write-back.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            op_q        <= OP_NOP;
            a_q         <= '0;
            b_q         <= '0;
            dst_q       <= '0;
            ms_prev_q   <= '0;
            result_q    <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            rf_q        <= '{default: '0};
`ifdef CALC_OVF_FLAG_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            dst_q       <= dst_d;
            ms_prev_q   <= ms_prev_d;
            result_q    <= result_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            rf_q        <= rf_d;
`ifdef CALC_OVF_FLAG_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign bus.result    = result_q;
    assign bus.busy      = busy_q;
    assign bus.res_valid = res_valid_q;
`ifdef CALC_OVF_FLAG_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_calc_datapath.sv
// Bench for calc_datapath (WIDTH=8): directed vectors, expected results
// queued at issue time and popped by a monitor on every res_valid pulse.
module tb_calc_datapath;
    import calc_pkg::*;

    typedef struct packed {
        logic [7:0] res;
        logic       ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   rv_count;
    exp_t exp_q[$];

    calc_if #(.WIDTH(8)) bus ();

    calc_datapath #(.WIDTH(8)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every res_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.res_valid) begin
            exp_t e;
            rv_count++;
            if (exp_q.size() == 0) begin
                check("unexpected res_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb result", 32'(bus.result), 32'(e.res));
`ifdef CALC_OVF_FLAG_EN
                check("sb ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [7:0] data);
        bus.WE  = 1'b1;
        bus.W1  = idx;
        bus.Din = data;
        tick();
        bus.WE  = 1'b0;
        bus.W1  = R_NONE;
    endtask

    // Issue one op; returns just after the start edge with MS_in back at NOP.
    task automatic start_op(input logic [2:0] op, input logic [2:0] dst,
                            input logic [7:0] res, input logic ovf);
        exp_t e;
        e.res = res;
        e.ovf = ovf;
        exp_q.push_back(e);
        bus.num_R1 = R_IN1;
        bus.num_R2 = R_IN2;
        bus.W1     = dst;
        bus.MS_in  = op;
        tick();
        bus.MS_in  = OP_NOP;
        bus.W1     = R_NONE;
    endtask

    task automatic rd(input logic [2:0] idx, output logic [7:0] val);
        bus.num_R1 = idx;
        #1;
        val = bus.Dout1;
    endtask

    initial begin
        logic [7:0] v;
        logic       busy_ok;
        int         rv0;

        errors     = 0;
        checks     = 0;
        rv_count   = 0;
        rst_n      = 1'b0;
        bus.WE     = 1'b0;
        bus.W1     = R_NONE;
        bus.num_R1 = R_IN1;
        bus.num_R2 = R_IN2;
        bus.MS_in  = OP_NOP;
        bus.Din    = '0;
        tick();
        tick();
        check("reset result", 32'(bus.result), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset res_valid", 32'(bus.res_valid), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1. ADD 5+3 -> R2
        wr(R_IN1, 8'd5);
        wr(R_IN2, 8'd3);
        #1;
        check("read Dout1", 32'(bus.Dout1), 32'd5);
        check("read Dout2", 32'(bus.Dout2), 32'd3);
        start_op(OP_ADD, R_RES, 8'd8, 1'b0);
        check("add busy after start", 32'(bus.busy), 32'd1);
        check("add no early valid", 32'(bus.res_valid), 32'd0);
        tick();
        check("add busy cleared", 32'(bus.busy), 32'd0);
        check("add res_valid", 32'(bus.res_valid), 32'd1);
        check("add result", 32'(bus.result), 32'd8);
        tick();
        check("add res_valid one cycle", 32'(bus.res_valid), 32'd0);
        rd(R_RES, v);
        check("add RF[2]", 32'(v), 32'd8);

        // 2. SUB 3-5 wraps with borrow
        wr(R_IN1, 8'd3);
        wr(R_IN2, 8'd5);
        start_op(OP_SUB, R_RES, 8'hFE, 1'b1);
        tick();
        tick();
        rd(R_RES, v);
        check("sub RF[2]", 32'(v), 32'hFE);

        // 3. MUL 15*17: busy for 9 cycles, result on the 9th edge
        wr(R_IN1, 8'd15);
        wr(R_IN2, 8'd17);
        start_op(OP_MUL, R_RES, 8'd255, 1'b0);
        busy_ok = bus.busy;
        for (int i = 1; i <= 8; i++) begin
            tick();
            busy_ok = busy_ok & bus.busy & ~bus.res_valid;
        end
        check("mul busy edges 0..8", 32'(busy_ok), 32'd1);
        tick();
        check("mul valid at edge 9", 32'(bus.res_valid), 32'd1);
        check("mul busy cleared", 32'(bus.busy), 32'd0);
        check("mul result", 32'(bus.result), 32'd255);
        tick();
        // 16*16 = 256: low half 0, upper half nonzero
        wr(R_IN1, 8'd16);
        wr(R_IN2, 8'd16);
        start_op(OP_MUL, R_RES, 8'd0, 1'b1);
        repeat (11) tick();

        // 4. held op starts once; reserved code ignored; start during MUL ignored
        rv0 = rv_count;
        exp_q.push_back('{res: 8'd32, ovf: 1'b0});
        bus.num_R1 = R_IN1;
        bus.num_R2 = R_IN2;
        bus.W1     = R_RES;
        bus.MS_in  = OP_ADD;
        repeat (5) tick();
        bus.MS_in  = OP_NOP;
        bus.W1     = R_NONE;
        repeat (3) tick();
        check("held op pulses", 32'(rv_count - rv0), 32'd1);
        rv0 = rv_count;
        bus.MS_in = 3'b101;
        repeat (3) tick();
        check("reserved op busy", 32'(bus.busy), 32'd0);
        bus.MS_in = OP_NOP;
        repeat (3) tick();
        check("reserved op pulses", 32'(rv_count - rv0), 32'd0);
        wr(R_IN1, 8'd2);
        wr(R_IN2, 8'd3);
        rv0 = rv_count;
        start_op(OP_MUL, 3'd4, 8'd6, 1'b0);
        tick();
        bus.MS_in = OP_ADD;
        tick();
        bus.MS_in = OP_NOP;
        repeat (12) tick();
        check("start while busy pulses", 32'(rv_count - rv0), 32'd1);
        rd(3'd4, v);
        check("mul RF[4]", 32'(v), 32'd6);

        // 5. reset during MUL cycle 4
        wr(R_IN1, 8'd15);
        wr(R_IN2, 8'd17);
        rd(R_RES, v);
        check("R2 before abort", 32'(v), 32'd32);
        exp_q.push_back('{res: 8'd255, ovf: 1'b0});
        start_op(OP_MUL, R_RES, 8'd255, 1'b0);
        // Neither queued entry will ever be delivered; the op is aborted.
        exp_q.delete();
        repeat (3) tick();
        rst_n = 1'b0;
        bus.num_R1 = R_RES;
        #1;
        check("abort result", 32'(bus.result), 32'd0);
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort RF[2]", 32'(bus.Dout1), 32'd0);
        tick();
        rv0 = rv_count;
        rst_n = 1'b1;
        repeat (12) tick();
        check("no valid after abort", 32'(rv_count - rv0), 32'd0);

        // 6. write-back beats external WE on the same index; others proceed
        wr(R_IN1, 8'd7);
        wr(R_IN2, 8'd9);
        start_op(OP_ADD, R_RES, 8'd16, 1'b0);
        bus.WE  = 1'b1;
        bus.W1  = R_RES;
        bus.Din = 8'hAA;
        tick();
        bus.WE  = 1'b0;
        bus.W1  = R_NONE;
        rd(R_RES, v);
        check("conflict RF[2]", 32'(v), 32'd16);
        wr(R_RES, 8'd0);
        start_op(OP_ADD, R_RES, 8'd16, 1'b0);
        bus.WE  = 1'b1;
        bus.W1  = 3'd3;
        bus.Din = 8'h55;
        tick();
        bus.WE  = 1'b0;
        bus.W1  = R_NONE;
        rd(3'd3, v);
        check("side write RF[3]", 32'(v), 32'h55);
        rd(R_RES, v);
        check("side write RF[2]", 32'(v), 32'd16);

        // XOR to index 7: result and pulse, no RF write
        start_op(OP_XOR, R_NONE, 8'h0E, 1'b0);
        tick();
        check("xor result", 32'(bus.result), 32'h0E);
        rd(3'd3, v);
        check("xor leaves RF[3]", 32'(v), 32'h55);
        repeat (3) tick();

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
